display_link_target_mp: RTL and testbench

Parametrised successor to the single-lane display target deserializer. It consumes pre-sampled (IDDR-oversampled) host-clock and multi-lane data nibbles in the c domain and recovers host bits on host-clock rising edges. Frames are delimited by a long host-clock-high sync. It decodes one header word per frame (local-bus write, I2C tri-state controls) plus a configurable number of pixel words. It also serialises a status/readback word back to the host on sdo. It sits between the pad IDDR primitives and the display pipeline and local bus.

---
 rtl/display_link_target_mp.sv | 256 +++++++++++++++++++++++++
 tb/tb_display_link_target_mp.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_link_target_mp.sv
// Multi-lane display link target deserialiser.
// Recovers host bits from oversampled host-clock/data samples, frames them on a
// long clock-high sync, decodes one header word plus PIXELS pixel words, and
// shifts a status/readback word back to the host on sdo.
// Pipeline: stage 1 registers edge/sync detection, stage 2 runs the frame FSM,
// so strobes appear two c cycles after the cycle holding the final edge.
// Handshake: outputs are single-cycle strobes with no back-pressure; a strobe
// qualifies the data/address outputs registered in the same cycle.
module display_link_target_mp #(
  parameter int SAMPLES = 4,
  parameter int LANES   = 1,
  parameter int PIX_W   = 16,
  parameter int PIXELS  = 4,
  parameter int SYNC_HI = 12,
  parameter int RD_W    = 16
) (
  input  logic                       c,
  input  logic                       reset_n,
  input  logic [SAMPLES-1:0]         ic,
  input  logic [LANES*SAMPLES-1:0]   id,
  output logic                       sdo,
  output logic                       pixel_valid,
  output logic                       pixel_sof,
  output logic [PIX_W-1:0]           pixel_data,
  output logic                       wvalid,
  output logic [3:0]                 addr,
  output logic [7:0]                 wdata,
  input  logic [RD_W-1:0]            rdata,
  output logic                       sda_t,
  output logic                       scl_t,
  input  logic                       sda_d,
  input  logic                       scl_d,
  input  logic                       fifostat,
  output logic                       frame_err,
  output logic                       overrun_err,
  output logic [1:0]                 dbg_state
);

  localparam int EDGES = PIX_W / LANES;
  localparam int BCW   = (EDGES > 1) ? $clog2(EDGES) : 1;
  localparam int PCW   = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int RUN_W = $clog2(SYNC_HI + 1);
  localparam int RB_W  = RD_W + 4;
  localparam int RBC_W = $clog2(RB_W + 1);

  localparam logic [BCW-1:0]   B_LAST = BCW'(EDGES - 1);
  localparam logic [PCW-1:0]   P_LAST = PCW'(PIXELS - 1);
  localparam logic [RUN_W-1:0] SYNC_V = RUN_W'(SYNC_HI);
  localparam logic [RUN_W-1:0] STEP_V = RUN_W'(SAMPLES);
  localparam logic [RBC_W-1:0] RB_LEN = RBC_W'(RB_W);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_PIXEL  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // ---------------- stage 1: edge and sync detection ----------------
  logic               prev_q;
  logic [RUN_W-1:0]   run_q, run_d, tcnt;
  logic               synced_q, synced_d;
  logic               sync_q, ev_q, ovr_q;
  logic [LANES-1:0]   bits_q, edge_bits;
  logic [SAMPLES:0]   ic_ext;
  logic [SAMPLES-1:0] rise;
  logic               multi, all_ones, sync_fire;

  assign ic_ext   = {ic, prev_q};
  assign rise     = ic & ~ic_ext[SAMPLES-1:0];
  assign multi    = |(rise & (rise - SAMPLES'(1)));
  assign all_ones = &ic;

  // Capture lane data at the earliest rising edge of the cycle.
  always_comb begin
    edge_bits = '0;
    for (int k = SAMPLES - 1; k >= 0; k--) begin
      if (rise[k]) begin
        for (int l = 0; l < LANES; l++) edge_bits[l] = id[l*SAMPLES + k];
      end
    end
  end

  // High-run counter: saturating add on all-high, else trailing-ones count.
  always_comb begin
    tcnt = '0;
    for (int k = 0; k < SAMPLES; k++) begin
      if (ic[k]) tcnt = tcnt + RUN_W'(1);
      else       tcnt = '0;
    end
    if (all_ones) run_d = (run_q >= SYNC_V - STEP_V) ? SYNC_V : run_q + STEP_V;
    else          run_d = tcnt;
  end

  // Sync fires once per high period; the flag re-arms on any low sample.
  assign sync_fire = all_ones & (run_d == SYNC_V) & ~synced_q;
  assign synced_d  = all_ones & (synced_q | sync_fire);

  // Stage 1 registers.
  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= 1'b0;
      run_q    <= '0;
      synced_q <= 1'b0;
      sync_q   <= 1'b0;
      ev_q     <= 1'b0;
      ovr_q    <= 1'b0;
      bits_q   <= '0;
    end else begin
      prev_q   <= ic[SAMPLES-1];
      run_q    <= run_d;
      synced_q <= synced_d;
      sync_q   <= sync_fire;
      ev_q     <= (|rise) & ~sync_fire;
      ovr_q    <= multi;
      bits_q   <= edge_bits;
    end
  end

  // ---------------- stage 2: frame FSM and readback ----------------
  logic [1:0]       state_q, state_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [PIX_W-1:0] word_q, word_d, word_next;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic             hsof_q, hsof_d;
  logic             sda_t_q, sda_t_d, scl_t_q, scl_t_d;
  logic [3:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wvalid_q, wvalid_d, pv_q, pv_d, psof_q, psof_d;
  logic [PIX_W-1:0] pdata_q, pdata_d;
  logic             ferr_q, ferr_d, oerr_q, oerr_d;
  logic [RB_W-1:0]  rb_q, rb_d;
  logic [RBC_W-1:0] rbc_q, rbc_d;
  logic             sdo_q, sdo_d;
  logic [PIX_W+LANES-1:0] word_cat;

  // New lane bits enter at the top so the first edge ends up at bit 0.
  assign word_cat  = {bits_q, word_q};
  assign word_next = word_cat[PIX_W+LANES-1:LANES];

  // Next-state logic: sync has priority, then edge processing.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    pcnt_d   = pcnt_q;
    hsof_d   = hsof_q;
    sda_t_d  = sda_t_q;
    scl_t_d  = scl_t_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wvalid_d = 1'b0;
    pv_d     = 1'b0;
    psof_d   = 1'b0;
    pdata_d  = pdata_q;
    ferr_d   = 1'b0;
    oerr_d   = ovr_q;
    rb_d     = rb_q;
    rbc_d    = rbc_q;
    sdo_d    = sdo_q;
    if (sync_q) begin
      state_d = S_HEADER;
      bcnt_d  = '0;
      ferr_d  = (state_q == S_PIXEL) || ((state_q == S_HEADER) && (bcnt_q != '0));
      rb_d    = {rdata, fifostat, sda_d, scl_d, 1'b1};
      rbc_d   = RB_LEN;
    end else if (ev_q && (state_q != S_HUNT)) begin
      if (rbc_q != '0) begin
        sdo_d = rb_q[0];
        rb_d  = rb_q >> 1;
        rbc_d = rbc_q - RBC_W'(1);
      end else begin
        sdo_d = 1'b0;
      end
      if ((state_q == S_HEADER) || (state_q == S_PIXEL)) begin
        word_d = word_next;
        if (bcnt_q == B_LAST) begin
          bcnt_d = '0;
          if (state_q == S_HEADER) begin
            hsof_d   = word_next[15];
            wvalid_d = word_next[14];
            sda_t_d  = word_next[13];
            scl_t_d  = word_next[12];
            addr_d   = word_next[11:8];
            wdata_d  = word_next[7:0];
            pcnt_d   = '0;
            state_d  = S_PIXEL;
          end else begin
            pv_d    = 1'b1;
            pdata_d = word_next;
            psof_d  = hsof_q && (pcnt_q == '0);
            pcnt_d  = pcnt_q + PCW'(1);
            if (pcnt_q == P_LAST) state_d = S_DONE;
          end
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
    end
  end

  // Stage 2 registers; I2C tri-state controls reset released (high).
  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_HUNT;
      bcnt_q   <= '0;
      word_q   <= '0;
      pcnt_q   <= '0;
      hsof_q   <= 1'b0;
      sda_t_q  <= 1'b1;
      scl_t_q  <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      pv_q     <= 1'b0;
      psof_q   <= 1'b0;
      pdata_q  <= '0;
      ferr_q   <= 1'b0;
      oerr_q   <= 1'b0;
      rb_q     <= '0;
      rbc_q    <= '0;
      sdo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      pcnt_q   <= pcnt_d;
      hsof_q   <= hsof_d;
      sda_t_q  <= sda_t_d;
      scl_t_q  <= scl_t_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      pv_q     <= pv_d;
      psof_q   <= psof_d;
      pdata_q  <= pdata_d;
      ferr_q   <= ferr_d;
      oerr_q   <= oerr_d;
      rb_q     <= rb_d;
      rbc_q    <= rbc_d;
      sdo_q    <= sdo_d;
    end
  end

  assign sdo         = sdo_q;
  assign pixel_valid = pv_q;
  assign pixel_sof   = psof_q;
  assign pixel_data  = pdata_q;
  assign wvalid      = wvalid_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign sda_t       = sda_t_q;
  assign scl_t       = scl_t_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_display_link_target_mp.sv
// Directed bench for display_link_target_mp: one 1-lane and one 4-lane instance.
module tb_display_link_target_mp;

  logic        c = 1'b0;
  logic        reset_n;
  logic [3:0]  ic, ic4, id;
  logic [15:0] id4, rdata;
  logic        sda_d, scl_d, fifostat;

  logic        sdo, pixel_valid, pixel_sof, wvalid, sda_t, scl_t, frame_err, overrun_err;
  logic [15:0] pixel_data;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic [1:0]  dbg_state;

  logic        sdo4, pixel_valid4, pixel_sof4, wvalid4, sda_t4, scl_t4, frame_err4, overrun_err4;
  logic [15:0] pixel_data4;
  logic [3:0]  addr4;
  logic [7:0]  wdata4;
  logic [1:0]  dbg_state4;

  display_link_target_mp #(.LANES(1)) u_dut (
    .c(c), .reset_n(reset_n), .ic(ic), .id(id), .sdo(sdo),
    .pixel_valid(pixel_valid), .pixel_sof(pixel_sof), .pixel_data(pixel_data),
    .wvalid(wvalid), .addr(addr), .wdata(wdata), .rdata(rdata),
    .sda_t(sda_t), .scl_t(scl_t), .sda_d(sda_d), .scl_d(scl_d), .fifostat(fifostat),
    .frame_err(frame_err), .overrun_err(overrun_err), .dbg_state(dbg_state)
  );

  display_link_target_mp #(.LANES(4)) u_dut4 (
    .c(c), .reset_n(reset_n), .ic(ic4), .id(id4), .sdo(sdo4),
    .pixel_valid(pixel_valid4), .pixel_sof(pixel_sof4), .pixel_data(pixel_data4),
    .wvalid(wvalid4), .addr(addr4), .wdata(wdata4), .rdata(rdata),
    .sda_t(sda_t4), .scl_t(scl_t4), .sda_d(sda_d), .scl_d(scl_d), .fifostat(fifostat),
    .frame_err(frame_err4), .overrun_err(overrun_err4), .dbg_state(dbg_state4)
  );

  // ---------------- clock / reset ----------------
  always #5 c = ~c;

  int cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  // ---------------- output monitors (log only) ----------------
  logic [15:0] got_pix[$], got4_pix[$];
  logic        got_sof[$], got4_sof[$];
  int          got_cyc[$], got4_cyc[$];
  int wv_cnt = 0, wv4_cnt = 0, wv_cyc = 0, wv4_cyc = 0, ferr_cnt = 0, ovr_cnt = 0;

  always @(negedge c) begin
    if (pixel_valid) begin
      got_pix.push_back(pixel_data); got_sof.push_back(pixel_sof); got_cyc.push_back(cyc);
    end
    if (pixel_valid4) begin
      got4_pix.push_back(pixel_data4); got4_sof.push_back(pixel_sof4); got4_cyc.push_back(cyc);
    end
    if (wvalid)      begin wv_cnt  <= wv_cnt + 1;  wv_cyc  <= cyc; end
    if (wvalid4)     begin wv4_cnt <= wv4_cnt + 1; wv4_cyc <= cyc; end
    if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    if (overrun_err) ovr_cnt  <= ovr_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_err = 0;
  int last_cyc = 0, p1 = 0, p4 = 0;
  logic [15:0] exp_q[$];
  logic        exp_sof_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic verify(input bit four);
    logic have;
    for (int i = 0; i < exp_q.size(); i++) begin
      have = four ? (p4 < got4_pix.size()) : (p1 < got_pix.size());
      if (have) begin
        check("pix_data", four ? got4_pix[p4] : got_pix[p1], exp_q[i]);
        check("pix_sof",  four ? got4_sof[p4] : got_sof[p1], exp_sof_q[i]);
        check("pix_cyc",  four ? got4_cyc[p4] : got_cyc[p1], exp_cyc_q[i]);
      end else begin
        check("pix_missing", 32'd0, 32'd1);
      end
      if (four) p4++; else p1++;
    end
    check("pix_count", four ? got4_pix.size() : got_pix.size(), four ? p4 : p1);
    exp_q.delete(); exp_sof_q.delete(); exp_cyc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(negedge c); ic = 4'h0; ic4 = 4'h0; end
  endtask

  task automatic sync(input bit four);
    repeat (4) begin @(negedge c); if (four) ic4 = 4'hF; else ic = 4'hF; end
  endtask

  // One host clock rising edge at sample 2 per cycle.
  task automatic edge1(input logic b);
    @(negedge c); ic = 4'b1100; id = {4{b}}; last_cyc = cyc;
  endtask

  task automatic edge4(input logic [3:0] n);
    @(negedge c); ic4 = 4'b1100;
    for (int l = 0; l < 4; l++) id4[l*4 +: 4] = {4{n[l]}};
    last_cyc = cyc;
  endtask

  task automatic word1(input logic [15:0] w, input bit is_pix, input logic sof);
    for (int i = 0; i < 16; i++) edge1(w[i]);
    if (is_pix) begin exp_q.push_back(w); exp_sof_q.push_back(sof); exp_cyc_q.push_back(last_cyc + 2); end
  endtask

  task automatic word4(input logic [15:0] w, input bit is_pix, input logic sof);
    for (int i = 0; i < 4; i++) edge4(w[4*i +: 4]);
    if (is_pix) begin exp_q.push_back(w); exp_sof_q.push_back(sof); exp_cyc_q.push_back(last_cyc + 2); end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, fbase, hdr_cyc, pbase;
    logic [15:0] hv;
    logic [19:0] rb_exp;

    reset_n = 1'b0; ic = 4'h0; ic4 = 4'h0; id = 4'h0; id4 = 16'h0;
    rdata = 16'h0; sda_d = 1'b0; scl_d = 1'b0; fifostat = 1'b0;
    repeat (3) @(negedge c);
    check("rst_sdo", sdo, 0);          check("rst_pv", pixel_valid, 0);
    check("rst_wv", wvalid, 0);        check("rst_sda_t", sda_t, 1);
    check("rst_scl_t", scl_t, 1);      check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);      check("rst_ferr", frame_err, 0);
    check("rst_oerr", overrun_err, 0); check("rst_state", dbg_state, 0);
    reset_n = 1'b1;

    // Before any sync: edges are ignored.
    repeat (2) begin @(negedge c); ic = 4'hF; end
    repeat (20) edge1(1'($urandom_range(0, 1)));
    idle(3);
    check("pre_wv", wv_cnt, 0);       check("pre_pix", got_pix.size(), 0);
    check("pre_sdo", sdo, 0);         check("pre_sda_t", sda_t, 1);
    check("pre_scl_t", scl_t, 1);     check("pre_state", dbg_state, 0);

    // Full frame, one lane.
    sync(0);
    base = wv_cnt;
    word1(16'hC5A3, 0, 0); hdr_cyc = last_cyc;
    word1(16'h1234, 1, 1); word1(16'hBEEF, 1, 0);
    word1(16'h0001, 1, 0); word1(16'hFFFF, 1, 0);
    idle(3);
    check("f1_wv_cnt", wv_cnt - base, 1); check("f1_wv_cyc", wv_cyc, hdr_cyc + 2);
    check("f1_addr", addr, 4'h5);         check("f1_wdata", wdata, 8'hA3);
    check("f1_sda_t", sda_t, 0);          check("f1_scl_t", scl_t, 0);
    check("f1_state", dbg_state, 3);
    verify(0);

    // Same frame, four lanes.
    sync(1);
    word4(16'hC5A3, 0, 0); hdr_cyc = last_cyc;
    word4(16'h1234, 1, 1); word4(16'hBEEF, 1, 0);
    word4(16'h0001, 1, 0); word4(16'hFFFF, 1, 0);
    idle(3);
    check("f4_wv_cnt", wv4_cnt, 1);        check("f4_wv_cyc", wv4_cyc, hdr_cyc + 2);
    check("f4_addr", addr4, 4'h5);         check("f4_wdata", wdata4, 8'hA3);
    check("f4_sda_t", sda_t4, 0);          check("f4_scl_t", scl_t4, 0);
    verify(1);

    // Sync after 7 header bits aborts the frame.
    fbase = ferr_cnt; base = wv_cnt;
    sync(0);
    repeat (7) edge1(1'b1);
    sync(0); idle(3);
    check("fe_pulse", ferr_cnt - fbase, 1);
    check("fe_no_wv", wv_cnt - base, 0);
    word1(16'h6B7C, 0, 0); word1(16'h00AA, 1, 0);
    idle(3);
    check("fe_wv_cnt", wv_cnt - base, 1);   check("fe_addr", addr, 4'hB);
    check("fe_wdata", wdata, 8'h7C);        check("fe_sda_t", sda_t, 1);
    check("fe_scl_t", scl_t, 0);            check("fe_once", ferr_cnt - fbase, 1);
    verify(0);

    // Two rising edges in one cycle: the first one's bit is used.
    base = ovr_cnt; hv = 16'h4321;
    sync(0); idle(1);
    @(negedge c); ic = 4'b0101; id = 4'b0001;
    for (int i = 1; i < 16; i++) edge1(hv[i]);
    idle(3);
    check("ov_pulse", ovr_cnt - base, 1);
    check("ov_wdata", wdata, 8'h21);  check("ov_addr", addr, 4'h3);

    // Readback shift-out, one edge at a time.
    rdata = 16'hA55A; fifostat = 1'b1; sda_d = 1'b0; scl_d = 1'b1;
    rb_exp = {16'hA55A, 4'b1011};
    sync(0); idle(1);
    for (int i = 0; i < 24; i++) begin
      edge1(1'b0); idle(2);
      check($sformatf("sdo_%0d", i), sdo, (i < 20) ? rb_exp[i] : 1'b0);
    end
    // Reload in the middle of a shift.
    sync(0); idle(1);
    for (int i = 0; i < 3; i++) edge1(1'b0);
    idle(2);
    check("rl_mid", sdo, rb_exp[2]);
    sync(0); idle(1);
    edge1(1'b0); idle(2); check("rl_start", sdo, 1);
    edge1(1'b0); idle(2); check("rl_bit1", sdo, 1);

    // Reset in the middle of a pixel.
    sync(0);
    word1(16'hC5A3, 0, 0); word1(16'h1111, 1, 1); word1(16'h2222, 1, 0);
    repeat (8) edge1(1'b1);
    @(negedge c); reset_n = 1'b0; #1;
    check("mr_pv", pixel_valid, 0);   check("mr_wv", wvalid, 0);
    check("mr_sda_t", sda_t, 1);      check("mr_scl_t", scl_t, 1);
    check("mr_addr", addr, 0);        check("mr_wdata", wdata, 0);
    check("mr_pdata", pixel_data, 0); check("mr_sdo", sdo, 0);
    check("mr_state", dbg_state, 0);
    verify(0);
    repeat (2) @(negedge c);
    reset_n = 1'b1;
    pbase = got_pix.size();
    repeat (24) edge1(1'($urandom_range(0, 1)));
    idle(3);
    check("mr_no_pix", got_pix.size() - pbase, 0);
    check("mr_hunt", dbg_state, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
